// File: rtl/multi_shift_sequencer_pkg.sv
// Shared constants for the multi-cycle shift sequencer and the nBitShifter code space.
package multi_shift_sequencer_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  localparam logic [1:0] SH_LEFT  = 2'b00;
  localparam logic [1:0] SH_PASS  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;
  localparam logic [1:0] SH_ZERO  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StShift = SHIFT,
    StDone  = DONE
  } state_e;

endpackage

// File: rtl/multi_shift_sequencer.sv
// Drives an external single-step shifter once per clock and accumulates its output,
// giving a 0..2^AMT_W-1 position logical shift behind a start/busy/done handshake.
module multi_shift_sequencer
  import multi_shift_sequencer_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned AMT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [AMT_W-1:0] amount,
  input  logic             clr,
  input  logic [N-1:0]     dataIn,
  input  logic [N-1:0]     shifterOut,
  output logic [N-1:0]     Fout,
  output logic [1:0]       c,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result
);

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Shifter code kept in its own process so the acc -> shifter -> acc_d path
  // never feeds back into c.
  always_comb begin
    c = SH_PASS;
    unique case (state_q)
      StIdle:  c = (clr && !start) ? SH_ZERO : SH_PASS;
      StShift: c = dir_q ? SH_RIGHT : SH_LEFT;
      StDone:  c = SH_PASS;
      default: c = SH_PASS;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = dataIn;
          cnt_d   = amount;
          dir_d   = dir;
          state_d = (amount == '0) ? StDone : StShift;
        end else if (clr) begin
          acc_d = shifterOut;
        end
      end
      StShift: begin
        acc_d = shifterOut;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign Fout   = acc_q;
  assign result = acc_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_multi_shift_sequencer.sv
// Self-checking bench: sequencer plus a behavioural nBitShifter, checked against a
// whole-operation shift model.
module tb_multi_shift_sequencer;
  import multi_shift_sequencer_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned AMT_W = 2;

  logic             clk;
  logic             reset;
  logic             start;
  logic             dir;
  logic [AMT_W-1:0] amount;
  logic             clr;
  logic [N-1:0]     dataIn;
  logic [N-1:0]     shifterOut;
  logic [N-1:0]     Fout;
  logic [1:0]       c;
  logic             busy;
  logic             done;
  logic [N-1:0]     result;

  int checks   = 0;
  int failures = 0;

  multi_shift_sequencer #(
    .N    (N),
    .AMT_W(AMT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dir       (dir),
    .amount    (amount),
    .clr       (clr),
    .dataIn    (dataIn),
    .shifterOut(shifterOut),
    .Fout      (Fout),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // Behavioural nBitShifter
  always_comb begin
    case (c)
      SH_LEFT:  shifterOut = Fout << 1;
      SH_PASS:  shifterOut = Fout;
      SH_RIGHT: shifterOut = Fout >> 1;
      default:  shifterOut = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_shift(input logic [N-1:0] d, input logic r, input int k);
    logic [N-1:0] v;
    if (k >= int'(N)) v = '0;
    else if (r)       v = d >> k;
    else              v = d << k;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation, checked cycle by cycle; optionally pokes start/clr while busy.
  task automatic run_op(input logic [N-1:0] d, input logic r, input int k, input bit inject,
                        input bit with_clr);
    logic [1:0] exp_c;
    start  = 1'b1;
    clr    = with_clr;
    dataIn = d;
    dir    = r;
    amount = AMT_W'(k);
    #1;
    checks++;
    if (c !== SH_PASS) begin
      failures++;
      $display("FAIL start_code: c=%b expected %b", c, SH_PASS);
    end
    step();
    start  = 1'b0;
    clr    = 1'b0;
    dataIn = N'($urandom);
    dir    = 1'($urandom);
    amount = AMT_W'($urandom);
    exp_c  = r ? SH_RIGHT : SH_LEFT;
    for (int i = 0; i < k; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || c !== exp_c || Fout !== model_shift(d, r, i)) begin
        failures++;
        $display("FAIL shift_step%0d: busy=%b done=%b c=%b Fout=%b expected 1 0 %b %b",
                 i, busy, done, c, Fout, exp_c, model_shift(d, r, i));
      end
      if (inject) begin
        start  = 1'b1;
        clr    = 1'($urandom);
        dataIn = N'($urandom);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || c !== SH_PASS || result !== model_shift(d, r, k)) begin
      failures++;
      $display("FAIL done_cycle: done=%b busy=%b c=%b result=%b expected 1 1 %b %b",
               done, busy, c, result, SH_PASS, model_shift(d, r, k));
    end
    if (inject) begin
      start = 1'b1;
      clr   = 1'b1;
    end
    step();
    start = 1'b0;
    clr   = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || c !== SH_PASS || result !== model_shift(d, r, k)) begin
      failures++;
      $display("FAIL after_done: done=%b busy=%b c=%b result=%b expected 0 0 %b %b",
               done, busy, c, result, SH_PASS, model_shift(d, r, k));
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    clr    = 1'b0;
    dir    = 1'b0;
    amount = '0;
    dataIn = '0;
    step();
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== '0 || Fout !== '0 || c !== SH_PASS) begin
      failures++;
      $display("FAIL reset_state: done=%b busy=%b result=%b Fout=%b c=%b expected 0 0 0 0 01",
               done, busy, result, Fout, c);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_left();
    run_op(4'b1011, 1'b0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_right();
    run_op(4'b1011, 1'b1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_zero_amount();
    run_op(4'b0110, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore_and_clr();
    run_op(4'b1011, 1'b0, 2, 1'b1, 1'b0);
    clr = 1'b1;
    #1;
    checks++;
    if (c !== SH_ZERO) begin
      failures++;
      $display("FAIL clr_code: c=%b expected %b", c, SH_ZERO);
    end
    step();
    clr = 1'b0;
    #1;
    checks++;
    if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || c !== SH_PASS) begin
      failures++;
      $display("FAIL clr_result: result=%b done=%b busy=%b c=%b expected 0000 0 0 01",
               result, done, busy, c);
    end
  endtask

  task automatic test_start_clr_priority();
    run_op(4'b1001, 1'b0, 1, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    bit saw_done = 1'b0;
    start  = 1'b1;
    dataIn = 4'b1101;
    dir    = 1'b0;
    amount = 2'd3;
    step();
    start = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (result !== '0 || Fout !== '0 || busy !== 1'b0 || c !== SH_PASS || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: result=%b Fout=%b busy=%b c=%b done=%b expected 0 0 0 01 0",
               result, Fout, busy, c, done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done: saw_done=%b expected 0", saw_done);
    end
    run_op(4'b0111, 1'b1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_op(N'($urandom), 1'($urandom), int'($urandom_range(0, (1 << AMT_W) - 1)),
             1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    run_op(4'b0001, 1'b0, 3, 1'b0, 1'b0);
    run_op(4'b1000, 1'b1, 3, 1'b0, 1'b0);
    run_op(4'b1110, 1'b0, 0, 1'b0, 1'b0);
    run_op(4'b0101, 1'b1, 1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_zero_amount();
    test_busy_ignore_and_clr();
    test_start_clr_priority();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
